// File: rtl/accum_multiplier.sv
// Shift-and-add unsigned multiplier: one accumulate step per multiplier bit,
// full 2N-bit product after N+1 cycles; each release of reset starts a new operation.
module accum_multiplier #(
    parameter int N = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic [2*N-1:0]   out,
    output logic             done
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

    state_t          state;
    logic [2*N-1:0]  acc;
    logic [2*N-1:0]  mcand;
    logic [N-1:0]    mplr;
    logic [CW-1:0]   count;

    assign out = acc;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= LOAD;
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            count <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    mcand <= {{N{1'b0}}, multiplicand};
                    mplr  <= multiplier;
                    acc   <= '0;
                    count <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (mplr[0])
                        acc <= acc + mcand;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    count <= count + 1'b1;
                    // done is raised on the same edge as the last accumulate
                    if (count == CW'(N - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_accum_multiplier.sv
// Directed bench for accum_multiplier: table of operand/product vectors plus
// hand-written sequences for mid-run input changes, abort and done hold.
module tb_accum_multiplier;

    localparam int N = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    multiplicand = '0;
    logic [N-1:0]    multiplier = '0;
    logic [2*N-1:0]  out;
    logic            done;

    int errors = 0;
    int checks = 0;

    accum_multiplier #(.N(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out          (out),
        .done         (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reset for 2 cycles, release with a/b, optionally change inputs after LOAD,
    // then wait for done and check latency and product.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] p, input bit mid_change);
        int cyc;
        reset = 1'b0;
        tick();
        tick();
        chk("reset_out", out, '0);
        chk("reset_done", {63'd0, done}, 64'd1 & 64'd0);
        multiplicand = a;
        multiplier   = b;
        reset = 1'b1;
        cyc = 0;
        for (int i = 1; i <= N + 8; i++) begin
            tick();
            cyc = i;
            if (i == 1 && mid_change) begin
                multiplicand = 32'd9;
                multiplier   = 32'd9;
            end
            if (done) break;
        end
        chk("latency", 64'(cyc), 64'(N + 1));
        chk("done_high", {63'd0, done}, 64'd1);
        chk("product", out, p);
    endtask

    initial begin
        vecs[0] = '{32'd0,          32'd0,          64'd0};
        vecs[1] = '{32'd1,          32'd1,          64'd1};
        vecs[2] = '{32'd7,          32'd7,          64'd49};
        vecs[3] = '{32'd134,        32'd79,         64'd10586};
        vecs[4] = '{32'd127,        32'd127,        64'd16129};
        vecs[5] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE00000001};
        vecs[6] = '{32'hFFFFFFFF,   32'd1,          64'h00000000FFFFFFFF};
        vecs[7] = '{32'h80000000,   32'd2,          64'h0000000100000000};

        for (int v = 0; v < 8; v++)
            run_op(vecs[v].a, vecs[v].b, vecs[v].p, 1'b0);

        // operands changed during RUN must be ignored
        run_op(32'd5, 32'd3, 64'd15, 1'b1);

        // abort at edge 10 of a 100*100 operation
        reset = 1'b0;
        tick();
        multiplicand = 32'd100;
        multiplier   = 32'd100;
        reset = 1'b1;
        for (int i = 1; i <= 9; i++) tick();
        chk("mid_run_not_done", {63'd0, done}, 64'd0);
        reset = 1'b0;
        tick();
        chk("abort_out", out, '0);
        chk("abort_done", {63'd0, done}, 64'd0);

        run_op(32'd12, 32'd12, 64'd144, 1'b0);
        for (int i = 0; i < 5; i++) begin
            multiplicand = 32'($urandom);
            multiplier   = 32'($urandom);
            tick();
            chk("hold_done", {63'd0, done}, 64'd1);
            chk("hold_out", out, 64'd144);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
